// File: rtl/multicycle_cpu_pkg.sv
// ============================================================================
// Module   : multicycle_cpu_pkg
// Purpose  : Opcode constants and FSM state encoding shared by the CPU files.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package multicycle_cpu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_LW  = 2'b01;
    localparam logic [1:0] OP_SW  = 2'b10;
    localparam logic [1:0] OP_BEQ = 2'b11;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/multicycle_cpu_reg_file.sv
// ============================================================================
// Module   : reg_file
// Purpose  : 4-entry register file, two async read ports, one sync write
//            port and an async debug read port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic [1:0]        waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [1:0]        raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic [1:0]        raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o,
    input  logic [1:0]        dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o
);

    logic [3:0][DATA_W-1:0] regs_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q <= '0;
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o  = regs_q[raddr_a_i];
    assign rdata_b_o  = regs_q[raddr_b_i];
    assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

`default_nettype wire

// File: rtl/multicycle_cpu.sv
// ============================================================================
// Module   : multicycle_cpu
// Purpose  : Four-instruction multicycle CPU (ADD/LW/SW/BEQ) with req/ack
//            instruction and data memory handshakes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_cpu
    import multicycle_cpu_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int PC_W     = 8,
    parameter int DISP_REG = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [7:0]        imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              retire,
    output logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] disp_value
);

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [7:0]          ir_q, ir_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   res_q, res_d;

    logic                w_retire;
    logic                w_rf_we;
    logic [DATA_W-1:0]   w_rs_data;
    logic [DATA_W-1:0]   w_rt_data;

    wire  [1:0]          w_op = ir_q[7:6];
    wire  [1:0]          w_rs = ir_q[5:4];
    wire  [1:0]          w_rt = ir_q[3:2];
    wire  [1:0]          w_rd = ir_q[1:0];

    wire  [DATA_W-1:0]   w_imm_data = {{(DATA_W-2){ir_q[1]}}, ir_q[1:0]};
    wire  [PC_W-1:0]     w_imm_pc   = {{(PC_W-2){ir_q[1]}}, ir_q[1:0]};
    wire  [PC_W-1:0]     w_pc_inc   = pc_q + PC_W'(1);
    wire  [PC_W-1:0]     w_pc_br    = w_pc_inc + w_imm_pc;

    // Handshake outputs are gated by reset so they drop the moment reset rises.
    assign imem_req   = (state_q == ST_FETCH) && run && !reset;
    assign imem_addr  = pc_q;
    assign dmem_req   = (state_q == ST_MEM) && !reset;
    assign dmem_we    = dmem_req && (w_op == OP_SW);
    assign dmem_addr  = res_q;
    assign dmem_wdata = b_q;
    assign retire     = w_retire && !reset;
    assign pc         = pc_q;

    reg_file #(
        .DATA_W (DATA_W)
    ) u_reg_file (
        .clk        (clk),
        .reset      (reset),
        .we_i       (w_rf_we),
        .waddr_i    ((w_op == OP_ADD) ? w_rd : w_rt),
        .wdata_i    (res_q),
        .raddr_a_i  (w_rs),
        .rdata_a_o  (w_rs_data),
        .raddr_b_i  (w_rt),
        .rdata_b_o  (w_rt_data),
        .dbg_addr_i (2'(DISP_REG)),
        .dbg_data_o (disp_value)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        w_retire = 1'b0;
        w_rf_we  = 1'b0;

        unique case (state_q)
            ST_FETCH: begin
                if (imem_req && imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                a_d     = w_rs_data;
                b_d     = w_rt_data;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                unique case (w_op)
                    OP_ADD: begin
                        res_d   = a_q + b_q;
                        state_d = ST_WB;
                    end
                    OP_LW, OP_SW: begin
                        res_d   = a_q + w_imm_data;
                        state_d = ST_MEM;
                    end
                    default: begin
                        pc_d     = (a_q == b_q) ? w_pc_br : w_pc_inc;
                        w_retire = 1'b1;
                        state_d  = ST_FETCH;
                    end
                endcase
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    if (w_op == OP_SW) begin
                        pc_d     = w_pc_inc;
                        w_retire = 1'b1;
                        state_d  = ST_FETCH;
                    end else begin
                        res_d    = dmem_rdata;
                        state_d  = ST_WB;
                    end
                end
            end
            ST_WB: begin
                w_rf_we  = 1'b1;
                pc_d     = w_pc_inc;
                w_retire = 1'b1;
                state_d  = ST_FETCH;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_cpu.sv
// ============================================================================
// Module   : tb_multicycle_cpu
// Purpose  : Self-checking bench for multicycle_cpu against an ISA-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_cpu;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic       stray_iack = 1'b0;
    logic       imem_req, imem_ack;
    logic [7:0] imem_addr, imem_rdata;
    logic       dmem_req, dmem_we, dmem_ack;
    logic [7:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic       retire;
    logic [7:0] pc, disp_value;

    logic [7:0] imem [256];
    logic [7:0] dmem [256];
    int         dwait = 0;
    int         dcnt  = 0;

    int checks = 0;
    int errors = 0;

    // ISA-level reference state
    logic [7:0] m_reg [4];
    logic [7:0] m_pc;
    logic [7:0] m_mem [256];
    bit         m_st, m_mem_op;
    logic [7:0] m_st_a, m_st_d;

    always #5 clk = ~clk;

    multicycle_cpu #(.DATA_W(8), .PC_W(8), .DISP_REG(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .retire     (retire),
        .pc         (pc),
        .disp_value (disp_value)
    );

    assign imem_ack   = imem_req | stray_iack;
    assign imem_rdata = imem[imem_addr];
    assign dmem_ack   = dmem_req && (dcnt == dwait);
    assign dmem_rdata = dmem[dmem_addr];

    always @(posedge clk) begin
        if (dmem_req && !dmem_ack) dcnt <= dcnt + 1;
        else                       dcnt <= 0;
        if (dmem_req && dmem_we && dmem_ack) dmem[dmem_addr] = dmem_wdata;
    end

    task automatic clear_mems();
        for (int i = 0; i < 256; i++) begin
            imem[i] = 8'h00;
            dmem[i] = 8'h00;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
        m_pc = 8'h00;
        for (int i = 0; i < 256; i++) m_mem[i] = dmem[i];
    endtask

    task automatic model_step(output int lat);
        logic [7:0] ir, ea;
        int         off;
        ir  = imem[m_pc];
        off = ir[1] ? int'(ir[1:0]) - 4 : int'(ir[1:0]);
        ea  = 8'(int'(m_reg[ir[5:4]]) + off);
        m_st = 1'b0;
        m_mem_op = 1'b0;
        case (ir[7:6])
            2'b00: begin
                m_reg[ir[1:0]] = m_reg[ir[5:4]] + m_reg[ir[3:2]];
                m_pc = m_pc + 8'd1;
                lat = 4;
            end
            2'b01: begin
                m_reg[ir[3:2]] = m_mem[ea];
                m_pc = m_pc + 8'd1;
                m_mem_op = 1'b1;
                lat = 5;
            end
            2'b10: begin
                m_mem[ea] = m_reg[ir[3:2]];
                m_st = 1'b1;
                m_st_a = ea;
                m_st_d = m_reg[ir[3:2]];
                m_pc = m_pc + 8'd1;
                m_mem_op = 1'b1;
                lat = 4;
            end
            default: begin
                m_pc = (m_reg[ir[5:4]] == m_reg[ir[3:2]]) ? 8'(int'(m_pc) + 1 + off)
                                                          : m_pc + 8'd1;
                lat = 3;
            end
        endcase
    endtask

    task automatic do_reset(input bit run_v);
        reset = 1'b1;
        run   = run_v;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        reset = 1'b0;
        #1;
    endtask

    // Runs until the current instruction retires (bounded); starts in FETCH.
    task automatic exec_one(output int cyc, output bit tmo, output bit st_seen,
                            output logic [7:0] st_addr, output logic [7:0] st_data,
                            output int req_cyc, output bit stable);
        logic [7:0] a0, d0;
        logic       we0;
        bit         done;
        cyc = 0; tmo = 0; st_seen = 0; st_addr = 0; st_data = 0;
        req_cyc = 0; stable = 1; done = 0; a0 = 0; d0 = 0; we0 = 0;
        while (!done) begin
            cyc++;
            if (dmem_req === 1'b1) begin
                if (req_cyc == 0) begin
                    a0 = dmem_addr; d0 = dmem_wdata; we0 = dmem_we;
                end else if (dmem_addr !== a0 || dmem_wdata !== d0 || dmem_we !== we0) begin
                    stable = 0;
                end
                req_cyc++;
                if (dmem_ack && dmem_we) begin
                    st_seen = 1; st_addr = dmem_addr; st_data = dmem_wdata;
                end
            end
            if (retire === 1'b1) done = 1;
            else if (cyc >= 200) begin tmo = 1; done = 1; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        clear_mems();
        reset = 1'b1;
        run   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({imem_req, dmem_req, dmem_we, retire} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl got req/dreq/we/ret=%b expected 0000",
                     {imem_req, dmem_req, dmem_we, retire});
        end
        checks++;
        if (pc !== 8'h00 || disp_value !== 8'h00) begin
            errors++;
            $display("FAIL reset_state got pc=%h disp=%h expected 00/00", pc, disp_value);
        end
        model_reset();
        reset = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
            errors++;
            $display("FAIL first_fetch got req=%b addr=%h expected 1/00", imem_req, imem_addr);
        end
    endtask

    task automatic test_lw();
        int cyc, rc; bit tmo, ss, stb; logic [7:0] sa, sd;
        clear_mems();
        imem[0] = 8'h45;
        imem[1] = 8'h84;
        dmem[1] = 8'h2A;
        dwait   = 0;
        do_reset(1'b1);
        exec_one(cyc, tmo, ss, sa, sd, rc, stb);
        checks++;
        if (cyc != 5 || pc !== 8'h01) begin
            errors++;
            $display("FAIL lw_latency got cyc=%0d pc=%h expected 5/01", cyc, pc);
        end
        exec_one(cyc, tmo, ss, sa, sd, rc, stb);
        checks++;
        if (!ss || sa !== 8'h00 || sd !== 8'h2A || cyc != 4 || pc !== 8'h02) begin
            errors++;
            $display("FAIL lw_value got st=%b addr=%h data=%h cyc=%0d pc=%h expected 1/00/2a/4/02",
                     ss, sa, sd, cyc, pc);
        end
    endtask

    task automatic test_add();
        int cyc, rc; bit tmo, ss, stb; logic [7:0] sa, sd;
        logic [7:0] va [2], vb [2], exp_sum [2];
        va[0] = 8'h05; vb[0] = 8'h07; exp_sum[0] = 8'h0C;
        va[1] = 8'hFF; vb[1] = 8'h02; exp_sum[1] = 8'h01;
        for (int k = 0; k < 2; k++) begin
            clear_mems();
            imem[0] = 8'h45;
            imem[1] = 8'h4A;
            imem[2] = 8'h1B;
            dmem[1] = va[k];
            dmem[254] = vb[k];
            do_reset(1'b1);
            exec_one(cyc, tmo, ss, sa, sd, rc, stb);
            exec_one(cyc, tmo, ss, sa, sd, rc, stb);
            exec_one(cyc, tmo, ss, sa, sd, rc, stb);
            checks++;
            if (disp_value !== exp_sum[k] || cyc != 4 || pc !== 8'h03) begin
                errors++;
                $display("FAIL add_%0d got disp=%h cyc=%0d pc=%h expected %h/4/03",
                         k, disp_value, cyc, pc, exp_sum[k]);
            end
        end
    endtask

    task automatic test_beq();
        int cyc, rc; bit tmo, ss, stb; logic [7:0] sa, sd;
        clear_mems();
        imem[4] = 8'hC3;
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) exec_one(cyc, tmo, ss, sa, sd, rc, stb);
        for (int i = 0; i < 3; i++) begin
            exec_one(cyc, tmo, ss, sa, sd, rc, stb);
            checks++;
            if (cyc != 3 || pc !== 8'h04) begin
                errors++;
                $display("FAIL beq_self_%0d got cyc=%0d pc=%h expected 3/04", i, cyc, pc);
            end
        end
        clear_mems();
        imem[0] = 8'h45;
        imem[4] = 8'hC7;
        dmem[1] = 8'h09;
        do_reset(1'b1);
        for (int i = 0; i < 5; i++) exec_one(cyc, tmo, ss, sa, sd, rc, stb);
        checks++;
        if (cyc != 3 || pc !== 8'h05) begin
            errors++;
            $display("FAIL beq_not_taken got cyc=%0d pc=%h expected 3/05", cyc, pc);
        end
    endtask

    task automatic test_sw_wait();
        int cyc, rc; bit tmo, ss, stb; logic [7:0] sa, sd;
        clear_mems();
        imem[0] = 8'h49;
        imem[1] = 8'h8B;
        dmem[1] = 8'h5A;
        dwait   = 0;
        do_reset(1'b1);
        exec_one(cyc, tmo, ss, sa, sd, rc, stb);
        dwait = 3;
        exec_one(cyc, tmo, ss, sa, sd, rc, stb);
        checks++;
        if (cyc != 7 || rc != 4 || !stb) begin
            errors++;
            $display("FAIL sw_wait_timing got cyc=%0d req_cycles=%0d stable=%b expected 7/4/1",
                     cyc, rc, stb);
        end
        checks++;
        if (!ss || sa !== 8'hFF || sd !== 8'h5A || dmem[255] !== 8'h5A) begin
            errors++;
            $display("FAIL sw_wait_data got st=%b addr=%h data=%h mem=%h expected 1/ff/5a/5a",
                     ss, sa, sd, dmem[255]);
        end
        checks++;
        if (dmem_req !== 1'b0 || retire !== 1'b0 || pc !== 8'h02) begin
            errors++;
            $display("FAIL sw_after got dreq=%b retire=%b pc=%h expected 0/0/02",
                     dmem_req, retire, pc);
        end
        dwait = 0;
    endtask

    task automatic test_reset_mid_mem();
        int cyc, rc; bit tmo, ss, stb; logic [7:0] sa, sd;
        clear_mems();
        imem[0] = 8'h4D;
        dmem[1] = 8'h77;
        dwait   = 5;
        do_reset(1'b1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b1) begin
            errors++;
            $display("FAIL mid_mem_entry got dreq=%b expected 1", dmem_req);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (dmem_req !== 1'b0 || retire !== 1'b0 || pc !== 8'h00 || disp_value !== 8'h00) begin
            errors++;
            $display("FAIL mid_mem_reset got dreq=%b ret=%b pc=%h disp=%h expected 0/0/00/00",
                     dmem_req, retire, pc, disp_value);
        end
        @(negedge clk);
        @(negedge clk);
        dwait = 0;
        model_reset();
        reset = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
            errors++;
            $display("FAIL mid_mem_restart got req=%b addr=%h expected 1/00", imem_req, imem_addr);
        end
        exec_one(cyc, tmo, ss, sa, sd, rc, stb);
        checks++;
        if (disp_value !== 8'h77 || pc !== 8'h01 || cyc != 5) begin
            errors++;
            $display("FAIL mid_mem_rerun got disp=%h pc=%h cyc=%0d expected 77/01/5",
                     disp_value, pc, cyc);
        end
    endtask

    task automatic test_run_low_wrap();
        int cyc, rc, bad; bit tmo, ss, stb; logic [7:0] sa, sd;
        clear_mems();
        imem[0]   = 8'hC2;
        imem[255] = 8'h3F;
        do_reset(1'b0);
        stray_iack = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (imem_req !== 1'b0 || retire !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0 || pc !== 8'h00) begin
            errors++;
            $display("FAIL run_low got bad_cycles=%0d pc=%h expected 0/00", bad, pc);
        end
        stray_iack = 1'b0;
        run = 1'b1;
        #1;
        exec_one(cyc, tmo, ss, sa, sd, rc, stb);
        checks++;
        if (cyc != 3 || pc !== 8'hFF) begin
            errors++;
            $display("FAIL branch_back got cyc=%0d pc=%h expected 3/ff", cyc, pc);
        end
        exec_one(cyc, tmo, ss, sa, sd, rc, stb);
        checks++;
        if (cyc != 4 || pc !== 8'h00) begin
            errors++;
            $display("FAIL pc_wrap got cyc=%0d pc=%h expected 4/00", cyc, pc);
        end
    endtask

    task automatic test_random();
        int cyc, rc, lat, exp_cyc; bit tmo, ss, stb; logic [7:0] sa, sd;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 256; i++) begin
                imem[i] = 8'($urandom);
                dmem[i] = 8'($urandom);
            end
            dwait = 0;
            do_reset(1'b1);
            for (int n = 0; n < 40; n++) begin
                dwait = $urandom_range(0, 2);
                model_step(lat);
                exp_cyc = lat + (m_mem_op ? dwait : 0);
                exec_one(cyc, tmo, ss, sa, sd, rc, stb);
                checks++;
                if (tmo || cyc != exp_cyc) begin
                    errors++;
                    $display("FAIL rand_latency r%0d n%0d got cyc=%0d expected %0d", r, n, cyc, exp_cyc);
                end
                checks++;
                if (pc !== m_pc || disp_value !== m_reg[3]) begin
                    errors++;
                    $display("FAIL rand_state r%0d n%0d got pc=%h disp=%h expected %h/%h",
                             r, n, pc, disp_value, m_pc, m_reg[3]);
                end
                checks++;
                if (ss !== m_st || (m_st && (sa !== m_st_a || sd !== m_st_d))) begin
                    errors++;
                    $display("FAIL rand_store r%0d n%0d got st=%b addr=%h data=%h expected %b/%h/%h",
                             r, n, ss, sa, sd, m_st, m_st_a, m_st_d);
                end
            end
        end
        dwait = 0;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_add();
        test_beq();
        test_sw_wait();
        test_reset_mid_mem();
        test_run_low_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
